// File: rtl/gcn_pkg.sv
// Shared sizes, derived widths and FSM state type for the GCN aggregation stage.
`timescale 1ns/1ps
package gcn_pkg;

  localparam int FEATURE_ROWS   = 6;
  localparam int WEIGHT_COLS    = 3;
  localparam int NUM_EDGES      = 6;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int AGG_WIDTH      = 20;

  localparam int NODE_WIDTH     = $clog2(FEATURE_ROWS);
  localparam int COO_ADDR_WIDTH = $clog2(NUM_EDGES);
  localparam int CLASS_WIDTH    = $clog2(WEIGHT_COLS);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EDGE_SRC,
    EDGE_DST,
    ARGMAX,
    DONE
  } agg_state_t;

endpackage

// File: rtl/gcn_aggregation_block_argmax.sv
// Combinational argmax over one aggregated row; ties go to the lowest column.
`timescale 1ns/1ps
module argmax_unit
  import gcn_pkg::*;
#(
  parameter int COLS      = WEIGHT_COLS,
  parameter int VAL_WIDTH = AGG_WIDTH,
  parameter int IDX_WIDTH = CLASS_WIDTH
) (
  input  logic [COLS-1:0][VAL_WIDTH-1:0] vals_i,
  output logic [IDX_WIDTH-1:0]           idx_o
);

  logic [VAL_WIDTH-1:0] bestVal;

  // Strict greater-than keeps the earliest column on equal values.
  always_comb begin
    bestVal = vals_i[0];
    idx_o   = '0;
    for (int c = 1; c < COLS; c++) begin
      if (vals_i[c] > bestVal) begin
        bestVal = vals_i[c];
        idx_o   = IDX_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/gcn_aggregation_block.sv
// Aggregation stage: agg = (A+I)*(FM*WM) over a COO edge list, then per-node argmax.
`timescale 1ns/1ps
module gcn_aggregation_block
  import gcn_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_row_in,
  input  logic [1:0][NODE_WIDTH-1:0]                 coo_in,
  output logic [NODE_WIDTH-1:0]                      read_row,
  output logic [COO_ADDR_WIDTH-1:0]                  coo_address,
  output logic                                       enable_read_coo,
  output logic                                       busy,
  output logic                                       done_agg,
  output logic                                       coo_err,
  output logic [FEATURE_ROWS-1:0][CLASS_WIDTH-1:0]   y
);

  localparam logic [NODE_WIDTH-1:0]     LAST_NODE  = NODE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COO_ADDR_WIDTH-1:0] LAST_EDGE  = COO_ADDR_WIDTH'(NUM_EDGES - 1);
  localparam logic [NODE_WIDTH:0]       NODE_LIMIT = (NODE_WIDTH + 1)'(FEATURE_ROWS);

  agg_state_t                  state_q, state_d;
  logic [NODE_WIDTH-1:0]       nodeCnt_q, nodeCnt_d;
  logic [COO_ADDR_WIDTH-1:0]   edgeCnt_q, edgeCnt_d;
  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][AGG_WIDTH-1:0] agg_q;
  logic [FEATURE_ROWS-1:0][CLASS_WIDTH-1:0] y_q;
  logic                        cooErr_q;
  logic                        doneAgg_q;
  logic [NODE_WIDTH-1:0]       edgeU, edgeV;
  logic                        edgeValid;
  logic                        acceptStart;
  logic [CLASS_WIDTH-1:0]      bestClass;

  assign edgeU       = coo_in[0];
  assign edgeV       = coo_in[1];
  assign edgeValid   = ({1'b0, edgeU} < NODE_LIMIT) && ({1'b0, edgeV} < NODE_LIMIT);
  assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));

  assign y        = y_q;
  assign coo_err  = cooErr_q;
  assign done_agg = doneAgg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      nodeCnt_q <= '0;
      edgeCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nodeCnt_q <= nodeCnt_d;
      edgeCnt_q <= edgeCnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    nodeCnt_d       = nodeCnt_q;
    edgeCnt_d       = edgeCnt_q;
    read_row        = '0;
    coo_address     = '0;
    enable_read_coo = 1'b0;
    busy            = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = INIT;
          nodeCnt_d = '0;
        end
      end
      INIT: begin
        busy     = 1'b1;
        read_row = nodeCnt_q;
        if (nodeCnt_q == LAST_NODE) begin
          state_d   = EDGE_SRC;
          nodeCnt_d = '0;
          edgeCnt_d = '0;
        end else begin
          nodeCnt_d = nodeCnt_q + 1'b1;
        end
      end
      EDGE_SRC: begin
        busy            = 1'b1;
        enable_read_coo = 1'b1;
        coo_address     = edgeCnt_q;
        read_row        = edgeV;
        state_d         = EDGE_DST;
      end
      EDGE_DST: begin
        busy            = 1'b1;
        enable_read_coo = 1'b1;
        coo_address     = edgeCnt_q;
        read_row        = edgeU;
        if (edgeCnt_q == LAST_EDGE) begin
          state_d   = ARGMAX;
          nodeCnt_d = '0;
        end else begin
          edgeCnt_d = edgeCnt_q + 1'b1;
          state_d   = EDGE_SRC;
        end
      end
      ARGMAX: begin
        busy = 1'b1;
        if (nodeCnt_q == LAST_NODE) begin
          state_d = DONE;
        end else begin
          nodeCnt_d = nodeCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  argmax_unit #(
    .COLS      (WEIGHT_COLS),
    .VAL_WIDTH (AGG_WIDTH),
    .IDX_WIDTH (CLASS_WIDTH)
  ) u_argmax (
    .vals_i (agg_q[nodeCnt_q]),
    .idx_o  (bestClass)
  );

  // done_agg is registered off DONE, so it trails DONE entry by one edge and drops on restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      agg_q     <= '0;
      y_q       <= '0;
      cooErr_q  <= 1'b0;
      doneAgg_q <= 1'b0;
    end else begin
      doneAgg_q <= (state_q == DONE) && !start;
      if (acceptStart) begin
        cooErr_q <= 1'b0;
      end
      case (state_q)
        INIT: begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            agg_q[nodeCnt_q][c] <= AGG_WIDTH'(fm_wm_row_in[c]);
          end
        end
        EDGE_SRC: begin
          if (edgeValid) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              agg_q[edgeU][c] <= agg_q[edgeU][c] + AGG_WIDTH'(fm_wm_row_in[c]);
            end
          end else begin
            cooErr_q <= 1'b1;
          end
        end
        EDGE_DST: begin
          // A self edge was already counted once in EDGE_SRC.
          if (edgeValid && (edgeU != edgeV)) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              agg_q[edgeV][c] <= agg_q[edgeV][c] + AGG_WIDTH'(fm_wm_row_in[c]);
            end
          end
        end
        ARGMAX: y_q[nodeCnt_q] <= bestClass;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_aggregation_block.sv
// Randomised bench for gcn_aggregation_block against a matrix-level reference model.
`timescale 1ns/1ps
module tb_gcn_aggregation_block;
  import gcn_pkg::*;

  localparam int FR      = FEATURE_ROWS;
  localparam int WC      = WEIGHT_COLS;
  localparam int NE      = NUM_EDGES;
  localparam int LATENCY = 2 * FR + 2 * NE + 1;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [WC-1:0][DOT_PROD_WIDTH-1:0] fm_wm_row_in;
  logic [1:0][NODE_WIDTH-1:0]        coo_in;
  logic [NODE_WIDTH-1:0]             read_row;
  logic [COO_ADDR_WIDTH-1:0]         coo_address;
  logic                              enable_read_coo;
  logic                              busy;
  logic                              done_agg;
  logic                              coo_err;
  logic [FR-1:0][CLASS_WIDTH-1:0]    y;

  int unsigned fm [FR][WC];
  int          cooU [NE];
  int          cooV [NE];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcn_aggregation_block dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .fm_wm_row_in    (fm_wm_row_in),
    .coo_in          (coo_in),
    .read_row        (read_row),
    .coo_address     (coo_address),
    .enable_read_coo (enable_read_coo),
    .busy            (busy),
    .done_agg        (done_agg),
    .coo_err         (coo_err),
    .y               (y)
  );

  // Asynchronous-read memories for the FM*WM product and the COO list.
  always_comb begin
    fm_wm_row_in = '0;
    coo_in       = '0;
    if (int'(read_row) < FR) begin
      for (int c = 0; c < WC; c++) fm_wm_row_in[c] = DOT_PROD_WIDTH'(fm[int'(read_row)][c]);
    end
    if (int'(coo_address) < NE) begin
      coo_in[0] = NODE_WIDTH'(cooU[int'(coo_address)]);
      coo_in[1] = NODE_WIDTH'(cooV[int'(coo_address)]);
    end
  end

  // Reference: agg = (A+I)*P with P the FM*WM matrix, wrapped to AGG_WIDTH bits.
  task automatic model(output logic [FR-1:0][CLASS_WIDTH-1:0] ey, output bit eerr,
                       output int firstBad);
    longint agg [FR][WC];
    longint mask;
    int     best;
    mask     = (longint'(1) << AGG_WIDTH) - 1;
    eerr     = 1'b0;
    firstBad = -1;
    for (int i = 0; i < FR; i++)
      for (int c = 0; c < WC; c++) agg[i][c] = longint'(fm[i][c]);
    for (int e = 0; e < NE; e++) begin
      if (cooU[e] < FR && cooV[e] < FR) begin
        for (int c = 0; c < WC; c++) begin
          agg[cooU[e]][c] = (agg[cooU[e]][c] + longint'(fm[cooV[e]][c])) & mask;
          if (cooU[e] != cooV[e])
            agg[cooV[e]][c] = (agg[cooV[e]][c] + longint'(fm[cooU[e]][c])) & mask;
        end
      end else begin
        eerr = 1'b1;
        if (firstBad < 0) firstBad = e;
      end
    end
    for (int i = 0; i < FR; i++) begin
      best = 0;
      for (int c = 1; c < WC; c++) if (agg[i][c] > agg[i][best]) best = c;
      ey[i] = CLASS_WIDTH'(best);
    end
  endtask

  task automatic run_check(input string name, input int pulseAt);
    logic [FR-1:0][CLASS_WIDTH-1:0] ey;
    bit eerr;
    int firstBad, cnt, firstErr;
    bit seenDone, enBad;
    model(ey, eerr, firstBad);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done_agg !== 1'b0 || coo_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s accept: busy=%b done=%b err=%b expected 1/0/0", name, busy, done_agg, coo_err);
    end
    cnt = 0; firstErr = -1; seenDone = 0; enBad = 0;
    while (!seenDone && cnt < 100) begin
      if (cnt == pulseAt) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt++;
      if (coo_err === 1'b1 && firstErr < 0) firstErr = cnt;
      if (enable_read_coo !== ((cnt >= FR && cnt < FR + 2 * NE) ? 1'b1 : 1'b0)) enBad = 1;
      if (done_agg === 1'b1) seenDone = 1;
    end
    vectors++;
    if (!seenDone || cnt != LATENCY) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, cnt, LATENCY);
    end
    vectors++;
    if (enBad || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s enable/busy window: enBad=%0d busy=%b expected 0/0", name, enBad, busy);
    end
    vectors++;
    if (coo_err !== eerr) begin
      miscompares++;
      $display("[TB] FAIL %s coo_err: got %b expected %b", name, coo_err, eerr);
    end
    if (eerr) begin
      vectors++;
      if (firstErr != FR + 2 * firstBad + 1) begin
        miscompares++;
        $display("[TB] FAIL %s coo_err timing: got %0d expected %0d", name, firstErr, FR + 2 * firstBad + 1);
      end
    end
    for (int i = 0; i < FR; i++) begin
      vectors++;
      if (y[i] !== ey[i]) begin
        miscompares++;
        $display("[TB] FAIL %s y[%0d]: got %0d expected %0d", name, i, y[i], ey[i]);
      end
    end
  endtask

  task automatic set_row(input int r, input int unsigned a, input int unsigned b, input int unsigned c);
    fm[r][0] = a; fm[r][1] = b; fm[r][2] = c;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (y !== '0 || busy !== 1'b0 || done_agg !== 1'b0 || coo_err !== 1'b0 ||
        read_row !== '0 || coo_address !== '0 || enable_read_coo !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: y=%h busy=%b done=%b err=%b row=%0d addr=%0d en=%b expected all 0",
               y, busy, done_agg, coo_err, read_row, coo_address, enable_read_coo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_self_loop_edge();
    set_row(0, 0, 0, 10);
    set_row(1, 1, 2, 9);
    for (int r = 2; r < FR; r++) set_row(r, 3, 1, 0);
    cooU[0] = 0; cooV[0] = 1;
    for (int e = 1; e < NE; e++) begin cooU[e] = 2; cooV[e] = 2; end
    run_check("self_loop_edge", -1);
    vectors++;
    if (y[0] !== 2'd2 || y[1] !== 2'd2 || y[2] !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL self_loop_edge fixed: got y0=%0d y1=%0d y2=%0d expected 2 2 0", y[0], y[1], y[2]);
    end
  endtask

  task automatic test_ties();
    for (int r = 0; r < FR; r++) set_row(r, 5, 5, 5);
    for (int e = 0; e < NE; e++) begin cooU[e] = 4; cooV[e] = 4; end
    run_check("ties", -1);
    vectors++;
    if (y !== '0) begin
      miscompares++;
      $display("[TB] FAIL ties fixed: got y=%h expected 0", y);
    end
  endtask

  task automatic load_invalid();
    set_row(0, 0, 9, 0);
    for (int r = 1; r < FR; r++) set_row(r, 1, 1, 1);
    for (int e = 0; e < NE; e++) begin
      cooU[e] = $urandom_range(0, FR - 1);
      cooV[e] = $urandom_range(0, FR - 1);
    end
    cooU[3] = 7; cooV[3] = 0;
  endtask

  task automatic test_invalid_edge();
    load_invalid();
    run_check("invalid_edge", -1);
    vectors++;
    if (y[0] !== 2'd1 || coo_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL invalid_edge fixed: got y0=%0d err=%b expected 1 1", y[0], coo_err);
    end
  endtask

  task automatic test_busy_restart();
    load_invalid();
    run_check("busy_pulse", FR + 1);
    for (int e = 0; e < NE; e++) begin
      cooU[e] = $urandom_range(0, FR - 1);
      cooV[e] = $urandom_range(0, FR - 1);
    end
    run_check("restart_from_done", -1);
  endtask

  task automatic test_wraparound();
    for (int r = 0; r < FR; r++)
      for (int c = 0; c < WC; c++) fm[r][c] = $urandom_range(16'hFFF0, 16'hFFFF);
    fm[1][0] = 16'hFFFF;
    cooU[0] = 0; cooV[0] = 1;
    cooU[1] = 2; cooV[1] = 0;
    cooU[2] = 0; cooV[2] = 3;
    cooU[3] = 4; cooV[3] = 0;
    cooU[4] = 0; cooV[4] = 5;
    cooU[5] = 1; cooV[5] = 1;
    run_check("wraparound", -1);
  endtask

  task automatic randomize_case();
    for (int r = 0; r < FR; r++)
      for (int c = 0; c < WC; c++) fm[r][c] = $urandom_range(0, 16'hFFFF);
    for (int e = 0; e < NE; e++) begin
      cooU[e] = ($urandom_range(0, 9) == 0) ? $urandom_range(FR, 7) : $urandom_range(0, FR - 1);
      cooV[e] = ($urandom_range(0, 9) == 0) ? $urandom_range(FR, 7) : $urandom_range(0, FR - 1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      randomize_case();
      run_check("random", -1);
    end
  endtask

  task automatic test_reset_midrun();
    randomize_case();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (FR + 2 * NE + 2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (y !== '0 || busy !== 1'b0 || done_agg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun: y=%h busy=%b done=%b expected 0/0/0", y, busy, done_agg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (LATENCY) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (done_agg !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun idle: done=%b busy=%b expected 0/0", done_agg, busy);
    end
    randomize_case();
    run_check("after_reset", -1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int r = 0; r < FR; r++) for (int c = 0; c < WC; c++) fm[r][c] = 0;
    for (int e = 0; e < NE; e++) begin cooU[e] = 0; cooV[e] = 0; end
    test_reset();
    test_self_loop_edge();
    test_ties();
    test_invalid_edge();
    test_busy_restart();
    test_wraparound();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
